// File: rtl/blink_seq_pkg.sv
// Shared types and default widths for the blink sequencer.
package blink_seq_pkg;

    localparam int DEF_CNT_W = 8;
    localparam int DEF_PS_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/blink_prescaler.sv
// Programmable tick divider: one tick every (div+1) enabled cycles, restarted by clr.
module blink_prescaler #(
    parameter int PS_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            en,
    input  logic [PS_W-1:0] div,
    output logic            tick
);

    logic [PS_W-1:0] pcnt_reg;

    // Count stays frozen whenever en is low, so a paused run resumes mid-period.
    assign tick = en && (pcnt_reg == div);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            pcnt_reg <= '0;
        end else if (en) begin
            pcnt_reg <= tick ? '0 : pcnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/blink_sequencer.sv
// Run/pause/step counter sequencer with wrap or one-shot terminal count.
// Optional prescaler built only when BLINK_SEQ_PRESCALE_EN is defined.
module blink_sequencer
    import blink_seq_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int PS_W  = DEF_PS_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             step,
    input  logic             oneshot,
    input  logic [CNT_W-1:0] term,
    input  logic [PS_W-1:0]  prescale,
    output logic [CNT_W-1:0] cnt,
    output logic             tick,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             wrap_reg, wrap_next;
    logic             busy_reg, done_reg;

    logic run_en, run_tick, fresh_start, step_adv, advance;

    // stop outranks everything, so a RUN cycle with stop never advances.
    assign run_en      = (state_reg == RUN) && !stop;
    assign fresh_start = ((state_reg == IDLE) || (state_reg == DONE)) && start && !stop;
    assign step_adv    = (state_reg == PAUSE) && !stop && !start && step;

`ifdef BLINK_SEQ_PRESCALE_EN
    blink_prescaler #(
        .PS_W(PS_W)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (fresh_start),
        .en   (run_en),
        .div  (prescale),
        .tick (run_tick)
    );
`else
    logic unused_prescale;
    assign unused_prescale = ^prescale;
    assign run_tick        = run_en;
`endif

    assign advance = run_tick || step_adv;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        wrap_next  = 1'b0;
        case (state_reg)
            IDLE, DONE: begin
                if (stop) begin
                    state_next = IDLE;
                end else if (start) begin
                    state_next = RUN;
                    cnt_next   = '0;
                end
            end
            RUN: begin
                if (stop) state_next = PAUSE;
            end
            PAUSE: begin
                if (stop) begin
                    state_next = IDLE;
                end else if (start) begin
                    state_next = RUN;
                end
            end
            default: state_next = IDLE;
        endcase
        // advance is only ever true when no stop/start transition is pending.
        if (advance) begin
            if (cnt_reg != term) begin
                cnt_next = cnt_reg + 1'b1;
            end else if (oneshot) begin
                state_next = DONE;
            end else begin
                cnt_next  = '0;
                wrap_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            wrap_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            wrap_reg  <= wrap_next;
            busy_reg  <= (state_next == RUN) || (state_next == PAUSE);
            done_reg  <= (state_next == DONE);
        end
    end

    assign cnt  = cnt_reg;
    assign tick = advance;
    assign busy = busy_reg;
    assign done = done_reg;
    assign wrap = wrap_reg;

endmodule

// File: tb/tb_blink_sequencer.sv
// Scoreboard bench for blink_sequencer; honours BLINK_SEQ_PRESCALE_EN when defined.
module tb_blink_sequencer;

    localparam int CNT_W = 8;
    localparam int PS_W  = 4;
    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;

    typedef struct packed {
        logic [CNT_W-1:0] cnt;
        logic             busy;
        logic             done;
        logic             wrap;
        logic             tick;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             step = 1'b0;
    logic             oneshot = 1'b0;
    logic [CNT_W-1:0] term = '0;
    logic [PS_W-1:0]  prescale = '0;
    logic [CNT_W-1:0] cnt;
    logic             tick, busy, done, wrap;
    logic             tick_obs;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   m_state = S_IDLE;
    int   m_cnt   = 0;
    int   m_pre   = 0;
    int   cyc     = 0;

    blink_sequencer #(.CNT_W(CNT_W), .PS_W(PS_W)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .step(step),
        .oneshot(oneshot), .term(term), .prescale(prescale),
        .cnt(cnt), .tick(tick), .busy(busy), .done(done), .wrap(wrap)
    );

    always #5 clk = ~clk;

    function automatic exp_t obs();
        exp_t o;
        o.cnt = cnt; o.busy = busy; o.done = done; o.wrap = wrap; o.tick = tick_obs;
        return o;
    endfunction

    // Drive one cycle of inputs, predict the post-edge outputs, clock, land at edge+1.
    task automatic drive(input logic r, input logic s, input logic p, input logic st);
        exp_t e;
        int   per;
        logic adv;
        rst = r; start = s; stop = p; step = st;
`ifdef BLINK_SEQ_PRESCALE_EN
        per = int'(prescale) + 1;
`else
        per = 1;
`endif
        adv = 1'b0;
        e.wrap = 1'b0;
        if (m_state == S_RUN && !p) begin
            if (m_pre == per - 1) begin adv = 1'b1; m_pre = 0; end
            else m_pre++;
        end
        if (m_state == S_PAUSE && !p && !s && st) adv = 1'b1;
        e.tick = adv;
        if (r) begin
            m_state = S_IDLE; m_cnt = 0; m_pre = 0;
        end else if ((m_state == S_IDLE || m_state == S_DONE) && p) begin
            m_state = S_IDLE;
        end else if ((m_state == S_IDLE || m_state == S_DONE) && s) begin
            m_state = S_RUN; m_cnt = 0; m_pre = 0;
        end else if (m_state == S_RUN && p) begin
            m_state = S_PAUSE;
        end else if (m_state == S_PAUSE && p) begin
            m_state = S_IDLE;
        end else if (m_state == S_PAUSE && s) begin
            m_state = S_RUN;
        end else if (adv) begin
            if (m_cnt != int'(term)) m_cnt = (m_cnt + 1) % (1 << CNT_W);
            else if (oneshot) m_state = S_DONE;
            else begin m_cnt = 0; e.wrap = 1'b1; end
        end
        e.cnt  = CNT_W'(m_cnt);
        e.busy = (m_state == S_RUN) || (m_state == S_PAUSE);
        e.done = (m_state == S_DONE);
        sb.push_back(e);
        @(negedge clk);
        tick_obs = tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 0, 0);
            e = sb.pop_front();
            n_tests++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL reset cyc %0d: got %h required %h", cyc, obs(), e);
            end
        end
        n_tests++;
        if ({cnt, busy, done, wrap} !== {8'd0, 3'b000}) begin
            n_fail++;
            $display("FAIL reset_const: got cnt=%0d busy=%b done=%b wrap=%b required 0/0/0/0",
                     cnt, busy, done, wrap);
        end
    endtask

    task automatic test_wrap();
        exp_t e;
        int   exp_cnt[6]  = '{0, 1, 2, 3, 0, 1};
        logic exp_wrap[6] = '{0, 0, 0, 0, 1, 0};
        prescale = 0; term = 3; oneshot = 0;
        for (int i = 0; i < 6; i++) begin
            drive(0, (i == 0), 0, 0);
            e = sb.pop_front();
            n_tests++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL wrap_sb cyc %0d: got %h required %h", cyc, obs(), e);
            end
            n_tests++;
            if (cnt !== CNT_W'(exp_cnt[i]) || wrap !== exp_wrap[i]) begin
                n_fail++;
                $display("FAIL wrap_seq step %0d: got cnt=%0d wrap=%b required cnt=%0d wrap=%b",
                         i, cnt, wrap, exp_cnt[i], exp_wrap[i]);
            end
        end
    endtask

    task automatic test_oneshot();
        exp_t e;
        int   per;
        prescale = 2; term = 255; oneshot = 1;
`ifdef BLINK_SEQ_PRESCALE_EN
        per = 3;
`else
        per = 1;
`endif
        drive(1, 0, 0, 0);
        drive(0, 1, 0, 0);
        for (int i = 0; i < 256 * per + 2; i++) drive(0, 0, 0, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_tests++;
            if (obs() !== e && sb.size() == 0) begin
                n_fail++;
                $display("FAIL oneshot_sb cyc %0d: got %h required %h", cyc, obs(), e);
            end
        end
        n_tests++;
        if (cnt !== 8'd255 || done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL oneshot_end: got cnt=%0d done=%b busy=%b required 255/1/0",
                     cnt, done, busy);
        end
    endtask

    task automatic test_oneshot_trace();
        exp_t e;
        int   per;
        prescale = 2; term = 255; oneshot = 1;
`ifdef BLINK_SEQ_PRESCALE_EN
        per = 3;
`else
        per = 1;
`endif
        drive(1, 0, 0, 0);
        e = sb.pop_front();
        drive(0, 1, 0, 0);
        e = sb.pop_front();
        for (int i = 1; i <= 256 * per + 2; i++) begin
            drive(0, 0, 0, 0);
            e = sb.pop_front();
            n_tests++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL oneshot_trace cyc %0d: got %h required %h", cyc, obs(), e);
            end
            if (i == 256 * per - 1) begin
                n_tests++;
                if (cnt !== 8'd255 || done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL oneshot_pre_done: got cnt=%0d done=%b required 255/0", cnt, done);
                end
            end
        end
    endtask

    task automatic test_pause_step();
        exp_t e;
        int   exp_cnt[10] = '{0, 1, 2, 3, 4, 5, 5, 6, 7, 8};
        prescale = 0; term = 200; oneshot = 0;
        drive(1, 0, 0, 0);
        e = sb.pop_front();
        for (int i = 0; i < 12; i++) begin
            if (i == 0) drive(0, 1, 0, 0);
            else if (i == 6) drive(0, 0, 1, 0);
            else if (i >= 7 && i <= 9) drive(0, 0, 0, 1);
            else if (i == 10) drive(0, 1, 0, 0);
            else drive(0, 0, 0, 0);
            e = sb.pop_front();
            n_tests++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL pause_sb cyc %0d: got %h required %h", cyc, obs(), e);
            end
            if (i < 10) begin
                n_tests++;
                if (cnt !== CNT_W'(exp_cnt[i]) || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL pause_step %0d: got cnt=%0d busy=%b required cnt=%0d busy=1",
                             i, cnt, busy, exp_cnt[i]);
                end
            end
        end
        n_tests++;
        if (cnt !== 8'd9) begin
            n_fail++;
            $display("FAIL pause_resume: got cnt=%0d required 9", cnt);
        end
    endtask

    task automatic test_start_stop();
        exp_t e;
        logic [CNT_W-1:0] held;
        drive(0, 1, 1, 0);
        e = sb.pop_front();
        held = cnt;
        n_tests++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL both_run_sb: got %h required %h", obs(), e);
        end
        drive(0, 0, 0, 0);
        e = sb.pop_front();
        n_tests++;
        if (cnt !== held || busy !== 1'b1 || obs() !== e) begin
            n_fail++;
            $display("FAIL both_run_pause: got cnt=%0d busy=%b required cnt=%0d busy=1", cnt, busy, held);
        end
        drive(0, 1, 1, 0);
        e = sb.pop_front();
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || cnt !== held || obs() !== e) begin
            n_fail++;
            $display("FAIL both_pause_idle: got busy=%b done=%b cnt=%0d required 0/0/%0d",
                     busy, done, cnt, held);
        end
        drive(0, 0, 0, 1);
        e = sb.pop_front();
        n_tests++;
        if (cnt !== held || tick_obs !== 1'b0 || obs() !== e) begin
            n_fail++;
            $display("FAIL idle_step: got cnt=%0d tick=%b required cnt=%0d tick=0", cnt, tick_obs, held);
        end
    endtask

    task automatic test_step_done();
        exp_t e;
        prescale = 0; term = 2; oneshot = 1;
        drive(1, 0, 0, 0);
        drive(0, 1, 0, 0);
        drive(0, 0, 1, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (sb.size() == 0) begin
                n_tests++;
                if (obs() !== e || done !== 1'b1 || busy !== 1'b0 || cnt !== 8'd2) begin
                    n_fail++;
                    $display("FAIL step_done: got cnt=%0d done=%b busy=%b required 2/1/0", cnt, done, busy);
                end
            end
        end
        drive(0, 0, 0, 1);
        e = sb.pop_front();
        n_tests++;
        if (obs() !== e || cnt !== 8'd2 || tick_obs !== 1'b0) begin
            n_fail++;
            $display("FAIL done_step: got cnt=%0d tick=%b required 2/0", cnt, tick_obs);
        end
        drive(0, 1, 0, 0);
        e = sb.pop_front();
        n_tests++;
        if (obs() !== e || cnt !== 8'd0 || busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL done_restart: got cnt=%0d busy=%b done=%b required 0/1/0", cnt, busy, done);
        end
    endtask

    task automatic test_term_edges();
        exp_t e;
        int   first_wrap = -1;
        prescale = 0; term = 0; oneshot = 0;
        drive(1, 0, 0, 0);
        drive(0, 1, 0, 0);
        e = sb.pop_front();
        e = sb.pop_front();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0);
            e = sb.pop_front();
            n_tests++;
            if (obs() !== e || cnt !== 8'd0 || wrap !== 1'b1) begin
                n_fail++;
                $display("FAIL term0 %0d: got cnt=%0d wrap=%b required 0/1", i, cnt, wrap);
            end
        end
        term = 20;
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 0, 0);
            e = sb.pop_front();
        end
        term = 5;
        for (int i = 1; i <= 255; i++) begin
            drive(0, 0, 0, 0);
            e = sb.pop_front();
            n_tests++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL term_low_sb cyc %0d: got %h required %h", cyc, obs(), e);
            end
            if (wrap === 1'b1 && first_wrap < 0) first_wrap = i;
        end
        n_tests++;
        if (first_wrap != 252) begin
            n_fail++;
            $display("FAIL term_low_wrap: got first wrap at %0d required 252", first_wrap);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        prescale = 0; term = 255; oneshot = 0;
        drive(1, 0, 0, 0);
        drive(0, 1, 0, 0);
        for (int i = 0; i < 127; i++) drive(0, 0, 0, 0);
        while (sb.size() > 0) e = sb.pop_front();
        n_tests++;
        if (cnt !== 8'h7F || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_rst: got cnt=%0d busy=%b required 127/1", cnt, busy);
        end
        drive(1, 1, 0, 1);
        e = sb.pop_front();
        n_tests++;
        if (obs() !== e || {cnt, busy, done, wrap} !== {8'd0, 3'b000}) begin
            n_fail++;
            $display("FAIL rst_run: got cnt=%0d busy=%b done=%b wrap=%b required 0/0/0/0",
                     cnt, busy, done, wrap);
        end
        drive(0, 1, 0, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 1, 0);
        drive(1, 1, 0, 0);
        while (sb.size() > 1) e = sb.pop_front();
        e = sb.pop_front();
        n_tests++;
        if (obs() !== e || {cnt, busy, done} !== {8'd0, 2'b00}) begin
            n_fail++;
            $display("FAIL rst_pause: got cnt=%0d busy=%b done=%b required 0/0/0", cnt, busy, done);
        end
    endtask

    task automatic test_prescale_ignored();
        exp_t e;
        int   exp4;
`ifdef BLINK_SEQ_PRESCALE_EN
        exp4 = 0;
`else
        exp4 = 4;
`endif
        prescale = 15; term = 255; oneshot = 0;
        drive(1, 0, 0, 0);
        drive(0, 1, 0, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0);
        while (sb.size() > 1) e = sb.pop_front();
        e = sb.pop_front();
        n_tests++;
        if (obs() !== e || cnt !== CNT_W'(exp4)) begin
            n_fail++;
            $display("FAIL prescale15: got cnt=%0d required %0d", cnt, exp4);
        end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_oneshot();
        test_oneshot_trace();
        test_pause_step();
        test_start_stop();
        test_step_done();
        test_term_edges();
        test_reset_mid();
        test_prescale_ignored();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
